dma_line_writer: RTL and testbench

Host-memory write engine for the AFU: the initiator side of CCI-P channel 1, the counterpart to the MMIO responder path. On a start pulse it accepts a stream of 512-bit cache lines and issues one CCI-P write request per line to consecutive host cache-line addresses. It respects channel-1 almost-full backpressure and an outstanding-request limit, counts write responses back, and pulses done when every line has been acknowledged. It sits between the AFU's data producer (for example, the FIFO) and the Tx c1 / Rx c1 ports.

---
 rtl/ccip_dma_pkg.sv | 18 +
 rtl/dma_line_writer.sv | 123 ++++++++++++
 tb/tb_dma_line_writer.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ccip_dma_pkg.sv
// Shared CCI-P DMA definitions: cache-line address/data/tag widths, the
// cache-line address type and the write-engine state encoding.
package ccip_dma_pkg;

  localparam int unsigned CL_ADDR_W = 42;
  localparam int unsigned CL_DATA_W = 512;
  localparam int unsigned MDATA_W   = 16;

  typedef logic [CL_ADDR_W-1:0] t_cl_addr;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } t_dma_wr_state;

endpackage

// File: rtl/dma_line_writer.sv
// dma_line_writer: CCI-P channel-1 write initiator.
// On an accepted start it latches base_addr/num_lines, takes one 512-bit line
// per in_valid/in_ready handshake and issues one registered write request per
// line to consecutive cache-line addresses. It stalls on c1_almfull or when
// MAX_OUTSTANDING writes are unacknowledged, counts responses back, and
// pulses done once every line is acknowledged.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   start                one-cycle pulse, honoured only when idle
//   base_addr, num_lines transfer descriptor, latched on accepted start
//   in_valid/in_ready    line stream handshake, in_data is the payload
//   c1_almfull           channel-1 almost-full backpressure
//   c1_valid/addr/mdata/data  registered write request
//   c1_rsp_valid         one write response this cycle
//   busy, done           engine active / one-cycle completion pulse
//   rsp_err              sticky: response seen with nothing outstanding
module dma_line_writer
  import ccip_dma_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 64,
  parameter int unsigned LEN_W           = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [CL_ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]     num_lines,
  input  logic                 in_valid,
  input  logic [CL_DATA_W-1:0] in_data,
  output logic                 in_ready,
  input  logic                 c1_almfull,
  output logic                 c1_valid,
  output logic [CL_ADDR_W-1:0] c1_addr,
  output logic [MDATA_W-1:0]   c1_mdata,
  output logic [CL_DATA_W-1:0] c1_data,
  input  logic                 c1_rsp_valid,
  output logic                 busy,
  output logic                 done,
  output logic                 rsp_err
);

  localparam int unsigned     OUT_W   = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUTSTANDING);

  t_dma_wr_state    state, state_nxt;
  t_cl_addr         base_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] issued_q;
  logic [OUT_W-1:0] out_q, out_nxt;
  logic             hs;
  logic             start_ok;
  logic             last_line;
  logic             rsp_err_set;

  assign start_ok  = start && (state == IDLE);
  assign in_ready  = (state == ISSUE) && !c1_almfull && (out_q < OUT_MAX);
  assign hs        = in_valid && in_ready;
  assign last_line = (issued_q == (len_q - LEN_W'(1)));
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  // Outstanding bookkeeping. A response with nothing outstanding (and no issue
  // to pair with) is an error and must not underflow the counter.
  always_comb begin
    out_nxt     = out_q;
    rsp_err_set = 1'b0;
    if (hs && !c1_rsp_valid) begin
      out_nxt = out_q + OUT_W'(1);
    end else if (!hs && c1_rsp_valid) begin
      if (out_q == '0) rsp_err_set = 1'b1;
      else             out_nxt     = out_q - OUT_W'(1);
    end
    if (c1_rsp_valid && (state == IDLE || state == DONE)) rsp_err_set = 1'b1;
  end

  // DRAIN looks at the post-update count so the last response takes the
  // engine to DONE on the very next cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (num_lines == '0) ? DONE : ISSUE;
      ISSUE:   if (hs && last_line) state_nxt = DRAIN;
      DRAIN:   if (out_nxt == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      base_q   <= '0;
      len_q    <= '0;
      issued_q <= '0;
      out_q    <= '0;
      rsp_err  <= 1'b0;
      c1_valid <= 1'b0;
      c1_addr  <= '0;
      c1_mdata <= '0;
      c1_data  <= '0;
    end else begin
      state    <= state_nxt;
      c1_valid <= hs;
      if (hs) begin
        c1_addr  <= base_q + CL_ADDR_W'(issued_q);
        c1_mdata <= MDATA_W'(issued_q);
        c1_data  <= in_data;
        issued_q <= issued_q + LEN_W'(1);
      end
      if (start_ok) begin
        base_q   <= base_addr;
        len_q    <= num_lines;
        issued_q <= '0;
        out_q    <= '0;
        rsp_err  <= 1'b0;
      end else begin
        out_q <= out_nxt;
        if (rsp_err_set) rsp_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dma_line_writer.sv
module tb_dma_line_writer;
  import ccip_dma_pkg::*;

  localparam int MAXO = 4;
  localparam int LW   = 16;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 start = 1'b0;
  logic [CL_ADDR_W-1:0] base_addr = '0;
  logic [LW-1:0]        num_lines = '0;
  logic                 in_valid = 1'b0;
  logic [CL_DATA_W-1:0] in_data = '0;
  logic                 in_ready;
  logic                 c1_almfull = 1'b0;
  logic                 c1_valid;
  logic [CL_ADDR_W-1:0] c1_addr;
  logic [MDATA_W-1:0]   c1_mdata;
  logic [CL_DATA_W-1:0] c1_data;
  logic                 c1_rsp_valid = 1'b0;
  logic                 busy;
  logic                 done;
  logic                 rsp_err;

  dma_line_writer #(.MAX_OUTSTANDING(MAXO), .LEN_W(LW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .num_lines(num_lines), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .c1_almfull(c1_almfull), .c1_valid(c1_valid),
    .c1_addr(c1_addr), .c1_mdata(c1_mdata), .c1_data(c1_data),
    .c1_rsp_valid(c1_rsp_valid), .busy(busy), .done(done), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: transfer-level view (lines sent, writes unacknowledged).
  bit             m_active, m_done_now, m_err;
  int             m_len, m_sent, m_out;
  logic [41:0]    m_base;
  bit             e_valid;
  logic [41:0]    e_addr;
  logic [15:0]    e_mdata;
  logic [511:0]   e_data;

  // Stimulus knobs and host response emulation.
  int  cyc = 0, x0 = 0;
  int  valid_pct = 100, almf_pct = 0, almf_lo = -1, almf_hi = -1;
  int  dly_lo = 3, dly_hi = 3;
  int  rsp_due[$];
  bit  rsp_hold = 0;
  int  rsp_credit = 0;
  bit  spurious = 0;
  int  n_c1 = 0, n_done = 0, n_almf_hs = 0;
  logic [41:0] last_addr;

  task automatic tick();
    bit hs, rsp, exp_rdy;
    int sent_before;
    in_valid = ($urandom_range(99) < valid_pct);
    for (int i = 0; i < 16; i++) in_data[i*32 +: 32] = $urandom();
    if (almf_lo >= 0) c1_almfull = (cyc - x0 >= almf_lo) && (cyc - x0 <= almf_hi);
    else              c1_almfull = ($urandom_range(99) < almf_pct);
    rsp = spurious;
    if (!rsp && rsp_due.size() > 0 && rsp_due[0] <= cyc && (!rsp_hold || rsp_credit > 0)) begin
      rsp = 1;
      void'(rsp_due.pop_front());
      if (rsp_hold) rsp_credit--;
    end
    c1_rsp_valid = rsp;
    @(negedge clk);
    exp_rdy = m_active && !m_done_now && (m_sent < m_len) && !c1_almfull && (m_out < MAXO);
    check_eq("in_ready", in_ready, exp_rdy);
    check_eq("busy", busy, m_active);
    check_eq("done", done, m_done_now);
    check_eq("rsp_err", rsp_err, m_err);
    check_eq("c1_valid", c1_valid, e_valid);
    if (e_valid) begin
      check_eq("c1_addr", c1_addr, e_addr);
      check_eq("c1_mdata", c1_mdata, e_mdata);
      check_eq("c1_data", c1_data, e_data);
    end
    if (c1_valid === 1'b1) begin
      n_c1++;
      last_addr = c1_addr;
      rsp_due.push_back(cyc + $urandom_range(dly_hi, dly_lo));
    end
    if (done === 1'b1) n_done++;
    if (in_valid && in_ready && c1_almfull) n_almf_hs++;
    // model update
    hs = in_valid && exp_rdy;
    sent_before = m_sent;
    e_valid = hs;
    if (hs) begin
      e_addr  = m_base + 42'(m_sent);
      e_mdata = 16'(m_sent);
      e_data  = in_data;
    end
    if (rsp && !hs) begin
      if (m_out > 0) m_out--;
      else           m_err = 1;
    end
    if (hs && !rsp) m_out++;
    if (hs) m_sent++;
    if (rsp && (!m_active || m_done_now)) m_err = 1;
    if (m_done_now) begin
      m_done_now = 0;
      m_active   = 0;
    end else if (m_active) begin
      if (sent_before == m_len && m_out == 0) m_done_now = 1;
    end else if (start) begin
      m_active   = 1;
      m_base     = base_addr;
      m_len      = int'(num_lines);
      m_sent     = 0;
      m_out      = 0;
      m_err      = 0;
      m_done_now = (num_lines == '0);
    end
    @(posedge clk);
    #1;
    cyc++;
    start    = 1'b0;
    spurious = 1'b0;
  endtask

  task automatic run_xfer(input logic [41:0] b, input int len, input int restart_at);
    int c0, d0, k;
    c0 = n_c1;
    d0 = n_done;
    k  = 0;
    start     = 1'b1;
    base_addr = b;
    num_lines = LW'(len);
    x0        = cyc;
    tick();
    while (m_active && k < 500) begin
      if (k == restart_at) begin
        start     = 1'b1;
        base_addr = 42'h155;
        num_lines = LW'(7);
      end
      tick();
      k++;
    end
    check_eq("xfer_ends_idle", busy, 1'b0);
    check_eq("xfer_line_count", n_c1 - c0, len);
    check_eq("xfer_done_pulses", n_done - d0, 1);
  endtask

  task automatic drain_idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    logic [63:0] r64;
    int c0, d0, k;
    // reset values
    #1;
    check_eq("rst_in_ready", in_ready, 1'b0);
    check_eq("rst_c1_valid", c1_valid, 1'b0);
    check_eq("rst_c1_addr", c1_addr, '0);
    check_eq("rst_c1_mdata", c1_mdata, '0);
    check_eq("rst_c1_data", c1_data, '0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_rsp_err", rsp_err, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    drain_idle(2);

    // basic write, responses 3 cycles after each request
    valid_pct = 100; almf_pct = 0; dly_lo = 3; dly_hi = 3;
    run_xfer(42'h100, 4, -1);
    check_eq("basic_last_addr", last_addr, 42'h103);
    check_eq("basic_rsp_err", rsp_err, 1'b0);

    // almost-full on cycles 2..5 of an 8-line transfer
    n_almf_hs = 0;
    almf_lo = 2; almf_hi = 5;
    run_xfer(42'h2000, 8, -1);
    almf_lo = -1; almf_hi = -1;
    check_eq("almf_no_handshake", n_almf_hs, 0);
    check_eq("almf_last_addr", last_addr, 42'h2007);

    // outstanding limit with responses withheld
    rsp_hold = 1; rsp_credit = 0; dly_lo = 1; dly_hi = 1;
    c0 = n_c1; d0 = n_done;
    start = 1'b1; base_addr = 42'h40; num_lines = LW'(10); x0 = cyc;
    tick();
    repeat (10) tick();
    check_eq("limit_issued", n_c1 - c0, 4);
    check_eq("limit_in_ready", in_ready, 1'b0);
    rsp_credit = 1;
    repeat (6) tick();
    check_eq("limit_one_more", n_c1 - c0, 5);
    check_eq("limit_in_ready_again", in_ready, 1'b0);
    rsp_hold = 0;
    k = 0;
    while (m_active && k < 200) begin tick(); k++; end
    check_eq("limit_total", n_c1 - c0, 10);
    check_eq("limit_done", n_done - d0, 1);
    check_eq("limit_idle", busy, 1'b0);

    // zero-length transfer
    run_xfer(42'h77, 0, -1);

    // address wrap
    dly_lo = 1; dly_hi = 4;
    run_xfer(42'h3FF_FFFF_FFFF, 2, -1);
    check_eq("wrap_second_addr", last_addr, 42'h0);

    // start while busy is ignored
    run_xfer(42'h500, 6, 2);
    check_eq("restart_last_addr", last_addr, 42'h505);

    // spurious response in idle, cleared by the next start
    drain_idle(2);
    spurious = 1'b1;
    tick();
    tick();
    check_eq("spurious_err", rsp_err, 1'b1);
    run_xfer(42'h900, 3, -1);
    check_eq("spurious_cleared", rsp_err, 1'b0);

    // reset mid-transfer
    valid_pct = 100;
    start = 1'b1; base_addr = 42'hABC; num_lines = LW'(20); x0 = cyc;
    tick();
    repeat (4) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("abort_c1_valid", c1_valid, 1'b0);
    check_eq("abort_busy", busy, 1'b0);
    check_eq("abort_in_ready", in_ready, 1'b0);
    check_eq("abort_done", done, 1'b0);
    check_eq("abort_c1_addr", c1_addr, '0);
    check_eq("abort_c1_data", c1_data, '0);
    m_active = 0; m_done_now = 0; m_err = 0; m_sent = 0; m_out = 0; m_len = 0;
    e_valid = 0;
    rsp_due.delete();
    in_valid = 1'b0;
    c1_rsp_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc++;
    d0 = n_done;
    drain_idle(2);
    check_eq("abort_no_done", n_done - d0, 0);
    run_xfer(42'hABC, 5, -1);

    // randomized transfers
    valid_pct = 70; almf_pct = 25; dly_lo = 1; dly_hi = 6;
    for (int t = 0; t < 6; t++) begin
      r64 = {$urandom(), $urandom()};
      run_xfer(r64[41:0], $urandom_range(20, 1), -1);
      drain_idle($urandom_range(3, 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
